// File: rtl/rand_output_buffer.sv
// Two-channel random output buffer: DRBG block FIFO and seed FIFO, each read out
// byte-serially (LSB first) to the CPU on request.

module rand_obuf_chan #(
    parameter int unsigned WORD_BITS = 128,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LOW_WATER = 1,
    localparam int unsigned LW       = $clog2(DEPTH + 1),
    localparam int unsigned VW       = $clog2(DEPTH * (WORD_BITS / 8) + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [WORD_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    input  logic                 take,
    output logic [7:0]           head_byte_c,
    output logic [VW-1:0]        avail_c,
    output logic [LW-1:0]        level,
    output logic                 low
);
    localparam int unsigned WB = WORD_BITS / 8;
    localparam int unsigned PW = $clog2(WB);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [PW-1:0]        byte_ptr;
    logic [LW-1:0]        level_d;
    logic [WORD_BITS-1:0] head_word;
    logic                 push_c;
    logic                 pop_c;

    assign head_word   = mem[rd_ptr];
    assign head_byte_c = head_word[{byte_ptr, 3'b000} +: 8];
    assign avail_c     = VW'(level) * VW'(WB) - VW'(byte_ptr);

    // A word leaves the FIFO when its last byte is taken; flush blocks any push.
    assign push_c = valid && ready && !flush;
    assign pop_c  = take && (byte_ptr == PW'(WB - 1));

    always_comb begin
        level_d = level;
        if (flush) begin
            level_d = '0;
        end else if (push_c && !pop_c) begin
            level_d = level + LW'(1);
        end else if (pop_c && !push_c) begin
            level_d = level - LW'(1);
        end
    end

    // Storage and pointers; consumed or flushed words are scrubbed to zero.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            byte_ptr <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (take) begin
                byte_ptr <= pop_c ? '0 : byte_ptr + PW'(1);
            end
            if (pop_c) begin
                mem[rd_ptr] <= '0;
                rd_ptr      <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            ready <= 1'b1;
            low   <= 1'b1;
        end else begin
            level <= level_d;
            ready <= (32'(level_d) != DEPTH);
            low   <= (32'(level_d) <= LOW_WATER);
        end
    end
endmodule

module rand_output_buffer #(
    parameter int unsigned DRBG_BITS  = 128,
    parameter int unsigned SEED_BITS  = 256,
    parameter int unsigned DRBG_DEPTH = 4,
    parameter int unsigned SEED_DEPTH = 2,
    parameter int unsigned LOW_WATER  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [DRBG_BITS-1:0]                drbg_data_i,
    input  logic                                drbg_valid_i,
    output logic                                drbg_ready_o,
    input  logic [SEED_BITS-1:0]                seed_data_i,
    input  logic                                seed_valid_i,
    output logic                                seed_ready_o,
    input  logic                                rand_req,
    input  logic [1:0]                          rand_req_type,
    output logic [7:0]                          rand_byte,
    output logic                                rand_valid,
    output logic                                rand_err,
    output logic                                rand_busy,
    output logic [$clog2(DRBG_DEPTH+1)-1:0]     drbg_level_o,
    output logic [$clog2(SEED_DEPTH+1)-1:0]     seed_level_o,
    output logic                                drbg_low_o
);
    localparam int unsigned DVW = $clog2(DRBG_DEPTH * (DRBG_BITS / 8) + 1);
    localparam int unsigned SVW = $clog2(SEED_DEPTH * (SEED_BITS / 8) + 1);
    localparam int unsigned CW  = 3;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SERVE = 1'b1;

    logic [0:0]     state;
    logic [0:0]     state_d;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_d;
    logic           sel_seed;
    logic           sel_seed_d;
    logic [7:0]     byte_d;
    logic           valid_d;
    logic           err_d;
    logic           busy_d;
    logic           take_drbg_c;
    logic           take_seed_c;
    logic [7:0]     drbg_byte_c;
    logic [7:0]     seed_byte_c;
    logic [DVW-1:0] drbg_avail_c;
    logic [SVW-1:0] seed_avail_c;
    logic [3:0]     need_c;
    logic           req_seed_c;
    logic           req_ok_c;
    logic           seed_low_unused;

    rand_obuf_chan #(
        .WORD_BITS (DRBG_BITS),
        .DEPTH     (DRBG_DEPTH),
        .LOW_WATER (LOW_WATER)
    ) u_drbg (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .data        (drbg_data_i),
        .valid       (drbg_valid_i),
        .ready       (drbg_ready_o),
        .take        (take_drbg_c),
        .head_byte_c (drbg_byte_c),
        .avail_c     (drbg_avail_c),
        .level       (drbg_level_o),
        .low         (drbg_low_o)
    );

    rand_obuf_chan #(
        .WORD_BITS (SEED_BITS),
        .DEPTH     (SEED_DEPTH),
        .LOW_WATER (LOW_WATER)
    ) u_seed (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .data        (seed_data_i),
        .valid       (seed_valid_i),
        .ready       (seed_ready_o),
        .take        (take_seed_c),
        .head_byte_c (seed_byte_c),
        .avail_c     (seed_avail_c),
        .level       (seed_level_o),
        .low         (seed_low_unused)
    );

    always_comb begin
        case (rand_req_type)
            2'b00:   need_c = 4'd2;
            2'b01:   need_c = 4'd4;
            default: need_c = 4'd8;
        endcase
    end

    assign req_seed_c = (rand_req_type == 2'b11);
    assign req_ok_c   = req_seed_c ? (32'(seed_avail_c) >= 32'(need_c))
                                   : (32'(drbg_avail_c) >= 32'(need_c));

    // Next state and next registered outputs; the first byte goes out on the accept edge.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        sel_seed_d  = sel_seed;
        byte_d      = 8'h00;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        busy_d      = 1'b0;
        take_drbg_c = 1'b0;
        take_seed_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (rand_req) begin
                    if (flush || !req_ok_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_SERVE;
                        sel_seed_d  = req_seed_c;
                        cnt_d       = CW'(need_c - 4'd1);
                        valid_d     = 1'b1;
                        busy_d      = 1'b1;
                        byte_d      = req_seed_c ? seed_byte_c : drbg_byte_c;
                        take_seed_c = req_seed_c;
                        take_drbg_c = !req_seed_c;
                    end
                end
            end
            default: begin
                if (flush) begin
                    state_d = S_IDLE;
                    err_d   = (cnt != '0);
                end else if (cnt != '0) begin
                    cnt_d       = cnt - CW'(1);
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                    byte_d      = sel_seed ? seed_byte_c : drbg_byte_c;
                    take_seed_c = sel_seed;
                    take_drbg_c = !sel_seed;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel_seed   <= 1'b0;
            rand_byte  <= 8'h00;
            rand_valid <= 1'b0;
            rand_err   <= 1'b0;
            rand_busy  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sel_seed   <= sel_seed_d;
            rand_byte  <= byte_d;
            rand_valid <= valid_d;
            rand_err   <= err_d;
            rand_busy  <= busy_d;
        end
    end
endmodule

// File: tb/tb_rand_output_buffer.sv
// Scoreboard bench for rand_output_buffer: a byte-stream model predicts every output byte.

module tb_rand_output_buffer;
    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [127:0] drbg_data_i;
    logic         drbg_valid_i;
    logic         drbg_ready_o;
    logic [255:0] seed_data_i;
    logic         seed_valid_i;
    logic         seed_ready_o;
    logic         rand_req;
    logic [1:0]   rand_req_type;
    logic [7:0]   rand_byte;
    logic         rand_valid;
    logic         rand_err;
    logic         rand_busy;
    logic [2:0]   drbg_level_o;
    logic [1:0]   seed_level_o;
    logic         drbg_low_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    bit lvl_chk  = 1'b1;

    logic [7:0] drbg_m[$];
    logic [7:0] seed_m[$];
    logic [7:0] exp_q[$];

    rand_output_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .drbg_data_i   (drbg_data_i),
        .drbg_valid_i  (drbg_valid_i),
        .drbg_ready_o  (drbg_ready_o),
        .seed_data_i   (seed_data_i),
        .seed_valid_i  (seed_valid_i),
        .seed_ready_o  (seed_ready_o),
        .rand_req      (rand_req),
        .rand_req_type (rand_req_type),
        .rand_byte     (rand_byte),
        .rand_valid    (rand_valid),
        .rand_err      (rand_err),
        .rand_busy     (rand_busy),
        .drbg_level_o  (drbg_level_o),
        .seed_level_o  (seed_level_o),
        .drbg_low_o    (drbg_low_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lvl(input int sz, input int wb);
        return (sz + wb - 1) / wb;
    endfunction

    // Output monitor: every valid byte must be the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rand_valid) begin
                if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
                else check("byte", 64'(rand_byte), 64'(exp_q.pop_front()));
            end else begin
                check("byte_idle", 64'(rand_byte), 64'd0);
            end
        end
    end

    task automatic check_levels();
        check("drbg_level", 64'(drbg_level_o), 64'(lvl(drbg_m.size(), 16)));
        check("seed_level", 64'(seed_level_o), 64'(lvl(seed_m.size(), 32)));
        check("drbg_low", 64'(drbg_low_o), 64'(lvl(drbg_m.size(), 16) <= 1));
    endtask

    task automatic push_word(input bit seed, input logic [255:0] w);
        int k = 0;
        @(negedge clk);
        if (seed) begin seed_data_i = w; seed_valid_i = 1'b1; end
        else begin drbg_data_i = w[127:0]; drbg_valid_i = 1'b1; end
        while (!(seed ? seed_ready_o : drbg_ready_o) && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("push_wait", 64'(k < 64), 64'd1);
        @(negedge clk);
        seed_valid_i = 1'b0;
        drbg_valid_i = 1'b0;
        for (int i = 0; i < (seed ? 32 : 16); i++) begin
            if (seed) seed_m.push_back(w[8*i +: 8]);
            else drbg_m.push_back(w[8*i +: 8]);
        end
        if (lvl_chk) check_levels();
    endtask

    task automatic do_req(input logic [1:0] t, input bit hold);
        int n;
        int k = 0;
        bit ok;
        n = (t == 2'd0) ? 2 : (t == 2'd1) ? 4 : 8;
        @(negedge clk);
        ok = (t == 2'd3) ? (seed_m.size() >= n) : (drbg_m.size() >= n);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                if (t == 2'd3) exp_q.push_back(seed_m.pop_front());
                else exp_q.push_back(drbg_m.pop_front());
            end
        end
        rand_req_type = t;
        rand_req      = 1'b1;
        @(negedge clk);
        if (!hold) rand_req = 1'b0;
        check("req_err", 64'(rand_err), 64'(!ok));
        check("req_busy", 64'(rand_busy), 64'(ok));
        if (ok) begin
            while (rand_busy && k < 40) begin
                @(negedge clk);
                k++;
            end
            rand_req = 1'b0;
            check("latency", 64'(k), 64'(n));
            check("sb_drain", 64'(exp_q.size()), 64'd0);
        end else begin
            @(negedge clk);
            check("err_pulse", 64'(rand_err), 64'd0);
            check("err_no_valid", 64'(rand_valid), 64'd0);
        end
        if (lvl_chk) check_levels();
    endtask

    task automatic check_reset_state();
        check("rst_valid", 64'(rand_valid), 64'd0);
        check("rst_byte", 64'(rand_byte), 64'd0);
        check("rst_err", 64'(rand_err), 64'd0);
        check("rst_busy", 64'(rand_busy), 64'd0);
        check("rst_dlevel", 64'(drbg_level_o), 64'd0);
        check("rst_slevel", 64'(seed_level_o), 64'd0);
        check("rst_low", 64'(drbg_low_o), 64'd1);
        check("rst_dready", 64'(drbg_ready_o), 64'd1);
        check("rst_sready", 64'(seed_ready_o), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drbg_m.delete();
        seed_m.delete();
        exp_q.delete();
        check_reset_state();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] w;
        logic [255:0] w5;
        rst = 1'b1; flush = 1'b0; rand_req = 1'b0; rand_req_type = 2'b00;
        drbg_valid_i = 1'b0; seed_valid_i = 1'b0; drbg_data_i = '0; seed_data_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        check_reset_state();

        // 1/2: LSB-first slicing, short requests, refusal, seamless word crossing
        for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(i);
        w[255:128] = '0;
        push_word(1'b0, w);
        do_req(2'b01, 1'b0);
        do_req(2'b10, 1'b0);
        do_req(2'b10, 1'b0);
        for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(16 + i);
        push_word(1'b0, w);
        check("two_words", 64'(drbg_level_o), 64'd2);
        do_req(2'b10, 1'b0);
        do_req(2'b00, 1'b0);

        // 3: full FIFO back-pressure with a held fifth word
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w = {128'd0, $urandom(), $urandom(), $urandom(), $urandom()};
            push_word(1'b0, w);
        end
        check("full_ready", 64'(drbg_ready_o), 64'd0);
        w5 = {128'd0, $urandom(), $urandom(), $urandom(), $urandom()};
        lvl_chk = 1'b0;
        fork
            push_word(1'b0, w5);
            begin
                repeat (3) @(negedge clk);
                check("held_level", 64'(drbg_level_o), 64'd4);
                check("held_ready", 64'(drbg_ready_o), 64'd0);
                do_req(2'b10, 1'b0);
                do_req(2'b10, 1'b0);
            end
        join
        lvl_chk = 1'b1;
        repeat (2) @(negedge clk);
        check_levels();
        check("refull_ready", 64'(drbg_ready_o), 64'd0);
        repeat (5) do_req(2'b10, 1'b0);

        // 4: seed channel, including a request held high through service
        do_reset();
        do_req(2'b11, 1'b0);
        for (int i = 0; i < 32; i++) w[8*i +: 8] = 8'(i);
        push_word(1'b1, w);
        do_req(2'b11, 1'b1);
        do_req(2'b11, 1'b0);
        do_req(2'b11, 1'b1);
        do_req(2'b11, 1'b0);
        do_req(2'b11, 1'b0);

        // 5: flush on the third byte of a RAND64
        do_reset();
        w = {128'd0, $urandom(), $urandom(), $urandom(), $urandom()};
        push_word(1'b0, w);
        push_word(1'b0, ~w);
        push_word(1'b1, w);
        @(negedge clk);
        for (int i = 0; i < 8; i++) exp_q.push_back(drbg_m.pop_front());
        rand_req_type = 2'b10;
        rand_req = 1'b1;
        @(negedge clk);
        rand_req = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid", 64'(rand_valid), 64'd0);
        check("flush_err", 64'(rand_err), 64'd1);
        check("flush_busy", 64'(rand_busy), 64'd0);
        check("flush_left", 64'(exp_q.size()), 64'd5);
        exp_q.delete();
        drbg_m.delete();
        seed_m.delete();
        check_levels();
        @(negedge clk);
        check("flush_err_once", 64'(rand_err), 64'd0);
        check("flush_dready", 64'(drbg_ready_o), 64'd1);
        do_req(2'b00, 1'b0);
        do_req(2'b11, 1'b0);

        // 6: reset during service
        push_word(1'b0, w);
        @(negedge clk);
        for (int i = 0; i < 8; i++) exp_q.push_back(drbg_m.pop_front());
        rand_req_type = 2'b10;
        rand_req = 1'b1;
        @(negedge clk);
        rand_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        drbg_m.delete();
        seed_m.delete();
        check_reset_state();
        @(negedge clk);
        check("post_rst_err", 64'(rand_err), 64'd0);
        push_word(1'b0, ~w);
        do_req(2'b01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rand_output_buffer.md
Name: rand_output_buffer

Overview:
- Parametrised two-channel output buffer between the entropy back-end and the CPU pins.
- Accepts whole seed words from the conditioner and whole random blocks from the DRBG over valid/ready handshakes, and queues each stream in its own FIFO.
- Serves CPU requests byte-sliced over rand_byte, LSB first, with variable request lengths.
- Reports occupancy and low-water status so the DRBG can be refilled ahead of demand.

Parameters:
DRBG_BITS, 128, width of one DRBG block; must be a multiple of 64
SEED_BITS, 256, width of one conditioner seed word; must be a multiple of 64
DRBG_DEPTH, 4, DRBG FIFO depth in words (power of 2, >=2)
SEED_DEPTH, 2, seed FIFO depth in words (power of 2, >=2)
LOW_WATER, 1, drbg_low_o asserts when DRBG FIFO level <= LOW_WATER

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
flush  in  1  one-cycle pulse; discards all buffered data (health-test failure)
drbg_data_i  in  DRBG_BITS  DRBG random block
drbg_valid_i  in  1  DRBG block valid
drbg_ready_o  out  1  DRBG FIFO can accept
seed_data_i  in  SEED_BITS  conditioned seed word
seed_valid_i  in  1  seed valid
seed_ready_o  out  1  seed FIFO can accept
rand_req  in  1  CPU request, sampled only while rand_busy=0
rand_req_type  in  2  00=RAND16 (2 B), 01=RAND32 (4 B), 10=RAND64 (8 B), 11=SEED64 (8 B from seed channel)
rand_byte  out  8  output byte
rand_valid  out  1  rand_byte valid
rand_err  out  1  one-cycle pulse: request refused or aborted
rand_busy  out  1  request in service
drbg_level_o  out  $clog2(DRBG_DEPTH+1)  DRBG FIFO words held
seed_level_o  out  $clog2(SEED_DEPTH+1)  seed FIFO words held
drbg_low_o  out  1  drbg_level_o <= LOW_WATER

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FIFOs emptied; byte pointers 0; FSM to IDLE.
  - Outputs: rand_byte=0, rand_valid=0, rand_err=0, rand_busy=0, levels=0, drbg_low_o=1.
  - Ready outputs are 1 from the first cycle after reset.
- Input side (per channel):
  - ready_o = !full, registered-state based.
  - Push on valid&&ready at posedge.
  - No push while full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: level unchanged.
- Byte pointer (per channel), range 0..WB-1, where WB = word bits/8:
  - Bytes of the head word are emitted in order head[8*p+7:8*p].
  - When p = WB-1 and that byte is emitted: head word popped, p returns to 0.
  - A request crossing a word boundary continues seamlessly into the next word in the next cycle.
- Availability: avail = level*WB - p. A request needs avail >= N, where N = 2/4/8/8 by type.
- FSM:
  - IDLE:
    - rand_busy=0.
    - On rand_req=1: if avail(sel) >= N, go to SERVE with cnt=N and sel latched; otherwise rand_err=1 for one cycle and stay in IDLE.
  - SERVE:
    - rand_busy=1, rand_valid=1, one byte per cycle, cnt decrements.
    - After the Nth byte, return to IDLE.
    - rand_req is ignored while in SERVE.
- Latency: request sampled at edge t; bytes valid in cycles t+1..t+N; the next request can be sampled at edge t+N+1 at the earliest.
- rand_byte is forced to 0 whenever rand_valid=0. No consumed data remains visible.
- Consumed and flushed FIFO entries are overwritten with 0.
- flush:
  - Empties both FIFOs and zeros both pointers.
  - If asserted during SERVE: the remaining bytes are abandoned, rand_valid=0 from the next cycle, rand_err pulses once, FSM returns to IDLE.
  - A push in the same cycle as flush is dropped.
- Reset mid-SERVE: behaves as a full reset; no rand_err.
- Levels and drbg_low_o are registered, updated the cycle after push/pop/flush.

Test Plan:
1. Reset; push DRBG word 0x0F0E0D0C_0B0A0908_07060504_03020100; request type 01 -> rand_valid for 4 cycles with bytes 00,01,02,03; drbg_level_o stays 1 (pointer=4).
2. Continue from 1: request 10 -> bytes 04..0B. Request 10 again (4 B available) -> rand_err for 1 cycle, no rand_valid. Push word 0x1F..10, request 10 -> bytes 0C,0D,0E,0F,10,11,12,13; level goes 2->1 at the boundary.
3. With DRBG_DEPTH=4, push 4 words -> drbg_ready_o=0, and a 5th word held with valid=1 is not accepted. Consume 16 bytes (two RAND64) -> ready returns to 1 the cycle after the pop and the held word is accepted. drbg_low_o toggles at level<=1.
4. Seed channel empty, request 11 -> rand_err pulse. Push seed 0x1F1E..00 (32 B), request 11 four times -> 32 bytes 00..1F, seed_level_o goes 1->0 after the 4th request. rand_req held high during SERVE is not re-accepted until rand_busy=0.
5. During SERVE at the 3rd byte of RAND64, pulse flush -> rand_valid=0 the next cycle, one rand_err pulse, both levels 0. Any further request -> rand_err.
6. Assert rst mid-SERVE -> all outputs 0 the next cycle, no rand_err, levels 0, ready outputs 1 afterwards.
